disp_nibble_collector: RTL and testbench

- Receive-side counterpart of the display nibble multiplexer.
- Observes the time-multiplexed 4-bit DISP bus and its scan select S_CLK; S_CLK=1 phase carries bits [3:0], S_CLK=0 phase carries bits [7:4].
- Reassembles the 8-bit value, presents it with a one-cycle VALID pulse, and flags loss of scan activity.
- Used by on-board self-check and by the display-capture debug path.

---
 rtl/disp_nibble_collector_if.sv | 36 +++
 rtl/disp_nibble_collector.sv | 181 ++++++++++++++++++
 tb/tb_disp_nibble_collector.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/disp_nibble_collector_if.sv
// disp_nibble_collector_if
//   Groups the multiplexed display bus and the reassembled result.
//   master : the scan source and result consumer (drives S_CLK/DISP, reads results)
//   slave  : the collector (reads S_CLK/DISP, drives results)
//   S_CLK   - scan phase select (1: bits [3:0], 0: bits [7:4])
//   DISP    - multiplexed nibble
//   SEG_OUT - last complete reassembled byte {hi, lo}
//   VALID   - one-cycle pulse when SEG_OUT updates
//   CHANGED - one-cycle pulse with VALID when the new byte differs from the old one
//   STALE   - level, no scan activity seen for the timeout window
interface disp_nibble_collector_if;
  logic       S_CLK;
  logic [3:0] DISP;
  logic [7:0] SEG_OUT;
  logic       VALID;
  logic       CHANGED;
  logic       STALE;

  modport master (
    output S_CLK,
    output DISP,
    input  SEG_OUT,
    input  VALID,
    input  CHANGED,
    input  STALE
  );

  modport slave (
    input  S_CLK,
    input  DISP,
    output SEG_OUT,
    output VALID,
    output CHANGED,
    output STALE
  );
endinterface

// File: rtl/disp_nibble_collector.sv
// disp_nibble_collector
//   Receive side of the display nibble multiplexer. Synchronizes the scan
//   select and nibble bus, waits for the scan phase to settle, captures the
//   low nibble in the S_CLK=1 phase and the high nibble in the S_CLK=0 phase,
//   and publishes the byte with VALID/CHANGED pulses. STALE flags a scan that
//   has stopped toggling.
//   Ports:
//     CLK   - system clock, all state on rising edge
//     RST_N - asynchronous active-low reset
//     bus   - slave side of disp_nibble_collector_if
//   Parameters:
//     SETTLE  - cycles the synchronized S_CLK must be stable before sampling (>=1)
//     TIMEOUT - cycles without an S_CLK edge before STALE (> SETTLE)
module disp_nibble_collector #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  disp_nibble_collector_if.slave  bus
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(SETTLE);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  logic          s_meta_q, s_sync_q, s_prev_q;
  logic [3:0]    d_meta_q, d_sync_q;

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [3:0]    lo_q, lo_d;
  logic          got_lo_q, got_lo_d;
  logic [7:0]    seg_q, seg_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic          stale_q, stale_d;

  logic          scan_edge;
  logic          timeout_hit;
  logic [7:0]    new_byte;

  // Two-flop synchronizers for the asynchronous scan inputs; s_prev_q keeps
  // the previous synchronized level for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_meta_q <= 1'b0;
      s_sync_q <= 1'b0;
      s_prev_q <= 1'b0;
      d_meta_q <= 4'h0;
      d_sync_q <= 4'h0;
    end else begin
      s_meta_q <= bus.S_CLK;
      s_sync_q <= s_meta_q;
      s_prev_q <= s_sync_q;
      d_meta_q <= bus.DISP;
      d_sync_q <= d_meta_q;
    end
  end

  assign scan_edge   = (s_sync_q != s_prev_q);
  // The idle counter is cleared by an edge, so a timeout never coincides with one.
  assign timeout_hit = !scan_edge && (idle_q == IDLE_LAST);
  assign new_byte    = {d_sync_q, lo_q};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_HUNT;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      idle_q    <= '0;
      lo_q      <= 4'h0;
      got_lo_q  <= 1'b0;
      seg_q     <= 8'h00;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      lo_q      <= lo_d;
      got_lo_q  <= got_lo_d;
      seg_q     <= seg_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      stale_q   <= stale_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    got_lo_d  = got_lo_q;
    seg_d     = seg_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    stale_d   = stale_q;

    if (scan_edge) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_ONE;
    end else begin
      idle_d = idle_q;
    end

    if (timeout_hit && (state_q != ST_HUNT)) begin
      // Scan has stopped: drop any half frame and wait for activity again.
      stale_d  = 1'b1;
      state_d  = ST_HUNT;
      got_lo_d = 1'b0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (scan_edge) begin
            state_d = ST_SETTLE;
            phase_d = s_sync_q;
            cnt_d   = CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (scan_edge) begin
            // A new edge before settling is a glitch: restart, no capture.
            phase_d = s_sync_q;
            cnt_d   = CNT_ONE;
          end else if (cnt_q >= CNT_LAST) begin
            cnt_d   = CNT_FULL;
            state_d = ST_HOLD;
            if (phase_q) begin
              lo_d     = d_sync_q;
              got_lo_d = 1'b1;
            end else if (got_lo_q) begin
              seg_d     = new_byte;
              valid_d   = 1'b1;
              changed_d = (new_byte != seg_q);
              stale_d   = 1'b0;
              got_lo_d  = 1'b0;
            end
            // A hi phase without a preceding lo is a partial frame and is dropped.
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (scan_edge) begin
            state_d = ST_SETTLE;
            phase_d = s_sync_q;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  assign bus.SEG_OUT = seg_q;
  assign bus.VALID   = valid_q;
  assign bus.CHANGED = changed_q;
  assign bus.STALE   = stale_q;

endmodule

// File: tb/tb_disp_nibble_collector.sv
// tb_disp_nibble_collector
//   Directed, table-driven bench for disp_nibble_collector with SETTLE=4,
//   TIMEOUT=64 and a 20-cycle scan half-period. Each table row holds one
//   scan phase (S_CLK level, DISP value, length) and the expected outcome at
//   its end (VALID pulses seen, SEG_OUT, CHANGED at the pulse, STALE).
module tb_disp_nibble_collector;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  disp_nibble_collector_if dutBus ();

  disp_nibble_collector #(
    .SETTLE (4),
    .TIMEOUT(64)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (dutBus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       sClk;
    logic [3:0] disp;
    int         cycles;
    int         expValids;
    logic [7:0] expSeg;
    logic       expChanged;
    logic       expStale;
  } phaseVec_t;

  localparam int NUM_VECS = 22;
  phaseVec_t vecs [NUM_VECS];

  int compared = 0;
  int mismatched = 0;
  int wideErrors = 0;
  logic prevValid = 1'b0;

  task automatic checkOutput(input int row, input string what,
                             input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL row %0d %s: got 0x%0h, want 0x%0h", row, what, actual, expected);
    end
  endtask

  // Drives one scan phase, watching VALID/CHANGED every cycle, then checks the row.
  task automatic applyStimulus(input int row, input phaseVec_t v);
    int validCount;
    logic lastChanged;
    validCount  = 0;
    lastChanged = 1'b0;
    dutBus.S_CLK = v.sClk;
    dutBus.DISP  = v.disp;
    for (int c = 0; c < v.cycles; c++) begin
      @(negedge CLK);
      if (dutBus.VALID === 1'b1) begin
        validCount++;
        lastChanged = dutBus.CHANGED;
        if (prevValid) wideErrors++;
      end
      if (dutBus.CHANGED === 1'b1 && dutBus.VALID !== 1'b1) wideErrors++;
      prevValid = (dutBus.VALID === 1'b1);
      @(posedge CLK);
      #1;
    end
    checkOutput(row, "valid_count", validCount, v.expValids);
    checkOutput(row, "seg_out", {24'h0, dutBus.SEG_OUT}, {24'h0, v.expSeg});
    checkOutput(row, "stale", {31'h0, dutBus.STALE}, {31'h0, v.expStale});
    if (v.expValids > 0)
      checkOutput(row, "changed", {31'h0, lastChanged}, {31'h0, v.expChanged});
  endtask

  initial begin
    phaseVec_t pv;

    //            sClk  disp  cyc val seg    chg   stale
    // Plain scan of A5, twice
    vecs[0]  = '{1'b1, 4'h5, 20, 0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'hA, 20, 1, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'h5, 20, 0, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'hA, 20, 1, 8'hA5, 1'b0, 1'b0};
    // 2-cycle S_CLK glitch inside a lo phase while DISP changes
    vecs[4]  = '{1'b1, 4'h6,  8, 0, 8'hA5, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'h9,  2, 0, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'h6, 10, 0, 8'hA5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'hB, 20, 1, 8'hB6, 1'b1, 1'b0};
    // Short lo pulse then a hi phase with no lo: partial frame discarded
    vecs[8]  = '{1'b1, 4'hE,  2, 0, 8'hB6, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'h3, 20, 0, 8'hB6, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'hC, 20, 0, 8'hB6, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'h3, 20, 1, 8'h3C, 1'b1, 1'b0};
    // S_CLK held for 80 cycles: not stale at idle ~57, stale after 64
    vecs[12] = '{1'b0, 4'h3, 40, 0, 8'h3C, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'h3, 40, 0, 8'h3C, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 4'hC, 20, 0, 8'h3C, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 4'h3, 20, 1, 8'h3C, 1'b0, 1'b0};
    // New byte every frame: 00, FF, 0F
    vecs[16] = '{1'b1, 4'h0, 20, 0, 8'h3C, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 4'h0, 20, 1, 8'h00, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 4'hF, 20, 0, 8'h00, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 4'hF, 20, 1, 8'hFF, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 4'hF, 20, 0, 8'hFF, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'h0, 20, 1, 8'h0F, 1'b1, 1'b0};

    dutBus.S_CLK = 1'b0;
    dutBus.DISP  = 4'h0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput(-1, "reset_seg_out", {24'h0, dutBus.SEG_OUT}, 32'h0);
    checkOutput(-1, "reset_valid", {31'h0, dutBus.VALID}, 32'h0);
    checkOutput(-1, "reset_changed", {31'h0, dutBus.CHANGED}, 32'h0);
    checkOutput(-1, "reset_stale", {31'h0, dutBus.STALE}, 32'h0);
    RST_N = 1'b1;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset asserted mid-settle in a hi phase, one cycle before the capture
    pv = '{1'b1, 4'h1, 20, 0, 8'h0F, 1'b0, 1'b0};
    applyStimulus(100, pv);
    pv = '{1'b0, 4'h2, 5, 0, 8'h0F, 1'b0, 1'b0};
    applyStimulus(101, pv);
    RST_N = 1'b0;
    #1;
    checkOutput(102, "async_reset_seg_out", {24'h0, dutBus.SEG_OUT}, 32'h0);
    checkOutput(102, "async_reset_valid", {31'h0, dutBus.VALID}, 32'h0);
    checkOutput(102, "async_reset_changed", {31'h0, dutBus.CHANGED}, 32'h0);
    checkOutput(102, "async_reset_stale", {31'h0, dutBus.STALE}, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    prevValid = 1'b0;
    pv = '{1'b0, 4'h2, 20, 0, 8'h00, 1'b0, 1'b0};
    applyStimulus(103, pv);
    pv = '{1'b1, 4'h4, 20, 0, 8'h00, 1'b0, 1'b0};
    applyStimulus(104, pv);
    pv = '{1'b0, 4'h2, 20, 1, 8'h24, 1'b1, 1'b0};
    applyStimulus(105, pv);

    checkOutput(200, "pulse_width_errors", wideErrors, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
